// File: rtl/heard_arbiter.sv
// Round-robin arbiter sharing one heard indication port among NREQ say-style requesters via a one-entry buffer.
// Optional per-requester grant counters are enabled with the HEARD_ARBITER_STATS_EN macro.
module heard_arbiter #(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 192,
    parameter int SRC_W      = 2
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic [NREQ-1:0]            req_pending,
    input  logic [NREQ-1:0]            req__ENA,
    input  logic [NREQ*DATA_WIDTH-1:0] req_meth,
    input  logic [NREQ*DATA_WIDTH-1:0] req_v,
    output logic [NREQ-1:0]            req__RDY,
    output logic                       ind_heard__ENA,
    output logic [DATA_WIDTH-1:0]      ind_heard_heard_meth,
    output logic [DATA_WIDTH-1:0]      ind_heard_heard_v,
    output logic [SRC_W-1:0]           ind_heard_src,
    input  logic                       ind_heard__RDY,
    output logic                       busy
`ifdef HEARD_ARBITER_STATS_EN
    ,
    input  logic [SRC_W-1:0]           stat_sel,
    input  logic                       stat_clr,
    output logic [15:0]                stat_count
`endif
);

    logic                  valid;
    logic [DATA_WIDTH-1:0] meth_q;
    logic [DATA_WIDTH-1:0] v_q;
    logic [SRC_W-1:0]      src_q;
    logic [SRC_W-1:0]      prio;

    logic                  found;
    logic [SRC_W-1:0]      win;
    logic                  space;
    logic                  accept;
    logic                  issue;
    logic [DATA_WIDTH-1:0] meth_sel;
    logic [DATA_WIDTH-1:0] v_sel;

    // Grant stage: rotating priority scan starting at prio
    always_comb begin : grant_scan
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(prio) + k) % NREQ;
            if (!found && req_pending[idx]) begin
                found = 1'b1;
                win   = SRC_W'(idx);
            end
        end
    end

    // Reset also masks the grant so no requester sees ready while held in reset
    assign space  = nRST && (!valid || ind_heard__RDY);
    assign accept = found && space && req__ENA[win];
    assign issue  = valid && ind_heard__RDY;

    always_comb begin
        req__RDY = '0;
        if (found && space)
            req__RDY[win] = 1'b1;
    end

    assign meth_sel = req_meth[int'(win)*DATA_WIDTH +: DATA_WIDTH];
    assign v_sel    = req_v[int'(win)*DATA_WIDTH +: DATA_WIDTH];

    // Buffer stage: capture the winner, drain on sink ready, refill in the same cycle
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid  <= 1'b0;
            meth_q <= '0;
            v_q    <= '0;
            src_q  <= '0;
            prio   <= '0;
        end else if (accept) begin
            valid  <= 1'b1;
            meth_q <= meth_sel;
            v_q    <= v_sel;
            src_q  <= win;
            prio   <= (int'(win) == NREQ - 1) ? '0 : win + SRC_W'(1);
        end else if (issue) begin
            valid  <= 1'b0;
        end
    end

    assign ind_heard__ENA       = issue;
    assign ind_heard_heard_meth = meth_q;
    assign ind_heard_heard_v    = v_q;
    assign ind_heard_src        = src_q;
    assign busy                 = valid;

`ifdef HEARD_ARBITER_STATS_EN
    logic [15:0] grant_cnt [NREQ];

    // Stats stage: saturating per-requester accept counters, clear wins over increment
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NREQ; i++)
                grant_cnt[i] <= '0;
        end else if (stat_clr) begin
            for (int i = 0; i < NREQ; i++)
                grant_cnt[i] <= '0;
        end else if (accept && grant_cnt[win] != 16'hFFFF) begin
            grant_cnt[win] <= grant_cnt[win] + 16'd1;
        end
    end

    assign stat_count = (int'(stat_sel) < NREQ) ? grant_cnt[stat_sel] : 16'd0;
`endif

endmodule

// File: tb/tb_heard_arbiter.sv
// Self-checking bench for heard_arbiter: directed vector table, reset corner case, randomized model comparison.
module tb_heard_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 192;
    localparam int SW   = 2;

    logic              CLK = 1'b0;
    logic              nRST;
    logic [NREQ-1:0]   pend;
    logic [NREQ-1:0]   ena;
    logic [NREQ*DW-1:0] meth_in;
    logic [NREQ*DW-1:0] v_in;
    logic [NREQ-1:0]   rdy_out;
    logic              hena;
    logic [DW-1:0]     hmeth;
    logic [DW-1:0]     hv;
    logic [SW-1:0]     hsrc;
    logic              hrdy;
    logic              busy;
`ifdef HEARD_ARBITER_STATS_EN
    logic [SW-1:0]     stat_sel;
    logic              stat_clr;
    logic [15:0]       stat_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    heard_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .SRC_W(SW)) dut (
        .CLK                  (CLK),
        .nRST                 (nRST),
        .req_pending          (pend),
        .req__ENA             (ena),
        .req_meth             (meth_in),
        .req_v                (v_in),
        .req__RDY             (rdy_out),
        .ind_heard__ENA       (hena),
        .ind_heard_heard_meth (hmeth),
        .ind_heard_heard_v    (hv),
        .ind_heard_src        (hsrc),
        .ind_heard__RDY       (hrdy),
        .busy                 (busy)
`ifdef HEARD_ARBITER_STATS_EN
        ,
        .stat_sel             (stat_sel),
        .stat_clr             (stat_clr),
        .stat_count           (stat_count)
`endif
    );

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++)
            r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    typedef struct packed {
        logic [3:0] pend;
        logic [3:0] ena;
        logic       rdy;
        logic [7:0] mb;
        logic [7:0] vb;
        logic [3:0] e_rdy;
        logic       e_ena;
        logic       e_busy;
        logic [1:0] e_src;
        logic [7:0] e_m;
        logic [7:0] e_v;
    } vec_t;

    vec_t tbl [20];

    typedef struct {
        logic [DW-1:0] m;
        logic [DW-1:0] v;
        int            src;
    } ent_t;

    ent_t q[$];
    int   m_prio;

    initial begin
        // pend ena rdy mb vb | e_rdy e_ena e_busy e_src e_m e_v
        tbl[0]  = '{4'hF, 4'hF, 1'b1, 8'h10, 8'h20, 4'h1, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00};
        tbl[1]  = '{4'hF, 4'hF, 1'b1, 8'h10, 8'h20, 4'h2, 1'b1, 1'b1, 2'd0, 8'h10, 8'h20};
        tbl[2]  = '{4'hF, 4'hF, 1'b1, 8'h10, 8'h20, 4'h4, 1'b1, 1'b1, 2'd1, 8'h11, 8'h21};
        tbl[3]  = '{4'hF, 4'hF, 1'b1, 8'h10, 8'h20, 4'h8, 1'b1, 1'b1, 2'd2, 8'h12, 8'h22};
        tbl[4]  = '{4'hF, 4'hF, 1'b1, 8'h10, 8'h20, 4'h1, 1'b1, 1'b1, 2'd3, 8'h13, 8'h23};
        tbl[5]  = '{4'hF, 4'hF, 1'b1, 8'h10, 8'h20, 4'h2, 1'b1, 1'b1, 2'd0, 8'h10, 8'h20};
        for (int i = 6; i <= 10; i++)
            tbl[i] = '{4'hF, 4'hF, 1'b0, 8'h55, 8'h66, 4'h0, 1'b0, 1'b1, 2'd1, 8'h11, 8'h21};
        tbl[11] = '{4'hF, 4'hF, 1'b1, 8'h10, 8'h20, 4'h4, 1'b1, 1'b1, 2'd1, 8'h11, 8'h21};
        tbl[12] = '{4'h0, 4'h0, 1'b1, 8'h10, 8'h20, 4'h0, 1'b1, 1'b1, 2'd2, 8'h12, 8'h22};
        tbl[13] = '{4'h1, 4'h9, 1'b1, 8'h10, 8'h20, 4'h1, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00};
        tbl[14] = '{4'h0, 4'h0, 1'b1, 8'h10, 8'h20, 4'h0, 1'b1, 1'b1, 2'd0, 8'h10, 8'h20};
        tbl[15] = '{4'h8, 4'h4, 1'b1, 8'h10, 8'h20, 4'h8, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00};
        tbl[16] = '{4'h0, 4'h0, 1'b1, 8'h10, 8'h20, 4'h0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00};
        tbl[17] = '{4'h4, 4'h4, 1'b1, 8'hA3, 8'h3A, 4'h4, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00};
        tbl[18] = '{4'h0, 4'h0, 1'b1, 8'hA3, 8'h3A, 4'h0, 1'b1, 1'b1, 2'd2, 8'hA5, 8'h3C};
        tbl[19] = '{4'h9, 4'h0, 1'b1, 8'h10, 8'h20, 4'h8, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00};

        nRST    = 1'b0;
        pend    = '1;
        ena     = '1;
        hrdy    = 1'b1;
        meth_in = '1;
        v_in    = '1;
`ifdef HEARD_ARBITER_STATS_EN
        stat_sel = '0;
        stat_clr = 1'b0;
`endif
        #2;
        chk("reset_rdy",  DW'(rdy_out), '0);
        chk("reset_ena",  DW'(hena), '0);
        chk("reset_busy", DW'(busy), '0);
        chk("reset_meth", hmeth, '0);
        chk("reset_v",    hv, '0);
        chk("reset_src",  DW'(hsrc), '0);
        tick();
        tick();
        nRST = 1'b1;

        // Directed vector table
        for (int r = 0; r < 20; r++) begin
            pend = tbl[r].pend;
            ena  = tbl[r].ena;
            hrdy = tbl[r].rdy;
            for (int i = 0; i < NREQ; i++) begin
                meth_in[i*DW +: DW] = {184'b0, 8'(tbl[r].mb + 8'(i))};
                v_in[i*DW +: DW]    = {184'b0, 8'(tbl[r].vb + 8'(i))};
            end
            #1;
            chk($sformatf("vec%0d_rdy", r),  DW'(rdy_out), DW'(tbl[r].e_rdy));
            chk($sformatf("vec%0d_ena", r),  DW'(hena), DW'(tbl[r].e_ena));
            chk($sformatf("vec%0d_busy", r), DW'(busy), DW'(tbl[r].e_busy));
            if (tbl[r].e_busy) begin
                chk($sformatf("vec%0d_src", r),  DW'(hsrc), DW'(tbl[r].e_src));
                chk($sformatf("vec%0d_meth", r), hmeth, DW'(tbl[r].e_m));
                chk($sformatf("vec%0d_v", r),    hv, DW'(tbl[r].e_v));
            end
            tick();
        end

        // Reset mid-transfer: buffered entry must vanish and never issue
        pend = 4'h1; ena = 4'h1; hrdy = 1'b0;
        tick();
        pend = '0; ena = '0;
        #1;
        chk("mid_loaded_busy", DW'(busy), DW'(1));
        chk("mid_loaded_ena",  DW'(hena), '0);
        #2;
        nRST = 1'b0;
        #1;
        hrdy = 1'b1;
        pend = 4'h1;
        #1;
        chk("mid_reset_busy", DW'(busy), '0);
        chk("mid_reset_ena",  DW'(hena), '0);
        chk("mid_reset_rdy",  DW'(rdy_out), '0);
        tick();
        tick();
        pend = '0;
        nRST = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("mid_after_ena",  DW'(hena), '0);
            chk("mid_after_busy", DW'(busy), '0);
            tick();
        end

        // Randomized run against the queue model
        nRST = 1'b0;
        #1;
        nRST = 1'b1;
        m_prio = 0;
        q.delete();
        tick();
        for (int c = 0; c < 1500; c++) begin
            int win;
            int best;
            bit sp;
            logic [3:0] erdy;
            bit eena;
            pend = 4'($urandom);
            hrdy = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < NREQ; i++) begin
                meth_in[i*DW +: DW] = rand_word();
                v_in[i*DW +: DW]    = rand_word();
            end
            win  = -1;
            best = NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (pend[i] && ((i - m_prio + NREQ) % NREQ) < best) begin
                    best = (i - m_prio + NREQ) % NREQ;
                    win  = i;
                end
            end
            sp   = (q.size() == 0) || hrdy;
            erdy = (win >= 0 && sp) ? 4'(1 << win) : 4'h0;
            eena = (q.size() != 0) && hrdy;
            ena  = 4'($urandom);
            if ($urandom_range(0, 1) == 1)
                ena = ena | erdy;
            #1;
            chk("rnd_rdy",  DW'(rdy_out), DW'(erdy));
            chk("rnd_ena",  DW'(hena), DW'(eena));
            chk("rnd_busy", DW'(busy), DW'(q.size() != 0));
            if (q.size() != 0) begin
                chk("rnd_src",  DW'(hsrc), DW'(q[0].src));
                chk("rnd_meth", hmeth, q[0].m);
                chk("rnd_v",    hv, q[0].v);
            end
            if (eena)
                void'(q.pop_front());
            if (win >= 0 && sp && ena[win]) begin
                q.push_back('{m: meth_in[win*DW +: DW], v: v_in[win*DW +: DW], src: win});
                m_prio = (win + 1) % NREQ;
            end
            tick();
        end

`ifdef HEARD_ARBITER_STATS_EN
        // Grant counters: count, clear priority, saturation
        nRST = 1'b0;
        #1;
        nRST = 1'b1;
        tick();
        pend = 4'h2; ena = 4'h2; hrdy = 1'b1; stat_sel = 2'd1;
        for (int c = 0; c < 3; c++) tick();
        pend = '0; ena = '0;
        #1;
        chk("stat_three", DW'(stat_count), DW'(3));
        stat_sel = 2'd0;
        #1;
        chk("stat_other", DW'(stat_count), DW'(0));
        stat_sel = 2'd1;
        pend = 4'h2; ena = 4'h2; stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0; pend = '0; ena = '0;
        #1;
        chk("stat_clr", DW'(stat_count), DW'(0));
        pend = 4'h2; ena = 4'h2;
        for (int c = 0; c < 65535; c++) tick();
        pend = '0; ena = '0;
        #1;
        chk("stat_max", DW'(stat_count), DW'(16'hFFFF));
        pend = 4'h2; ena = 4'h2;
        tick();
        pend = '0; ena = '0;
        #1;
        chk("stat_sat", DW'(stat_count), DW'(16'hFFFF));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
